// File: rtl/uart_rx_framer.sv
// 8N1 UART receiver: synchronizes the line, frames bytes LSB first, and hands them to a
// valid/ready consumer with one-cycle frame_err and overrun pulses.
module uart_rx_framer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             sync1_q, sync1_d;
    logic             rx_s_q, rx_s_d;
    logic [1:0]       settle_q, settle_d;
    logic             armed_q, armed_d;
    logic             complete;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        complete    = 1'b0;
        sync1_d     = uart_rx;
        rx_s_d      = sync1_q;

        // The synchronizer resets to 1, so only arm once rx_s carries a real line sample:
        // a line already low when reset lifts must not be mistaken for a start bit.
        settle_d = {settle_q[0], 1'b1};
        armed_d  = armed_q | (settle_q[1] & rx_s_q);

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (armed_q && !rx_s_q) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        complete = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BREAK: begin
                if (rx_s_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A handshake in the completion cycle frees the holding register for the new byte.
        if (complete) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            settle_q    <= '0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer at 8 clocks per bit: framing, glitch rejection,
// break handling, overrun, same-cycle handshake and mid-frame reset.
module tb_uart_rx_framer;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int fe_cnt = 0;
    int ovr_cnt = 0;

    uart_rx_framer #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .uart_rx  (uart_rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Each pulse is high for exactly one clock, so it is seen on exactly one falling edge.
    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ovr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 8N1 frame driven on falling edges: start, 8 data bits LSB first, stop.
    // ready_at / rst_at (>= 0) pulse rx_ready high / rst_n low for the cycle starting at that offset.
    task automatic send_frame(input logic [7:0] data, input logic stop,
                              input int ready_at, input int rst_at);
        logic [9:0] bits;
        bits = {stop, data, 1'b0};
        for (int c = 0; c < 10 * CPB; c++) begin
            uart_rx = bits[c / CPB];
            if (ready_at >= 0) rx_ready = (c == ready_at);
            if (rst_at >= 0) rst_n = !(c == rst_at);
            @(negedge clk);
        end
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        uart_rx  = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", rx_valid, 0);
        check("reset_data", rx_data, 8'h00);
        check("reset_busy", busy, 0);
        check("reset_flags", {frame_err, overrun}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Plain byte, held until consumed.
        send_frame(8'hA5, 1'b1, -1, -1);
        check("a5_valid", rx_valid, 1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_idle", busy, 0);
        repeat (3) @(negedge clk);
        check("a5_held", rx_valid, 1);
        consume();
        check("a5_consumed", rx_valid, 0);
        check("a5_data_kept", rx_data, 8'hA5);

        // Three-cycle low glitch: start-bit midpoint sees high again.
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        check("glitch_start", busy, 1);
        uart_rx = 1'b1;
        rx_ready = 1'b1;
        repeat (10) @(negedge clk);
        rx_ready = 1'b0;
        check("glitch_idle", busy, 0);
        check("glitch_valid", rx_valid, 0);
        check("glitch_flags", fe_cnt + ovr_cnt, 0);

        // Bad stop bit followed by a held-low line: one frame_err only.
        send_frame(8'h3C, 1'b0, -1, -1);
        check("break_busy", busy, 1);
        repeat (40) @(negedge clk);
        check("break_fe_once", fe_cnt, 1);
        uart_rx = 1'b1;
        repeat (10) @(negedge clk);
        check("break_fe_total", fe_cnt, 1);
        check("break_valid", rx_valid, 0);
        check("break_idle", busy, 0);
        send_frame(8'h81, 1'b1, -1, -1);
        check("after_break_valid", rx_valid, 1);
        check("after_break_data", rx_data, 8'h81);
        consume();

        // Back-to-back without consumption: second byte overruns.
        send_frame(8'h11, 1'b1, -1, -1);
        send_frame(8'h22, 1'b1, -1, -1);
        check("ovr_data", rx_data, 8'h11);
        check("ovr_valid", rx_valid, 1);
        check("ovr_pulses", ovr_cnt, 1);

        // Handshake on the completion edge (offset 78 precedes the 79th rising edge).
        send_frame(8'h22, 1'b1, 10 * CPB - 2, -1);
        check("hs_data", rx_data, 8'h22);
        check("hs_valid", rx_valid, 1);
        check("hs_no_ovr", ovr_cnt, 1);

        // Reset in the middle of data bit 4 of 8'hFF.
        send_frame(8'hFF, 1'b1, -1, 5 * CPB + 3);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_flags", {fe_cnt[7:0], ovr_cnt[7:0]}, {8'd1, 8'd1});
        repeat (5) @(negedge clk);
        send_frame(8'h5A, 1'b1, -1, -1);
        check("post_rst_valid", rx_valid, 1);
        check("post_rst_data", rx_data, 8'h5A);
        check("post_rst_flags", {fe_cnt[7:0], ovr_cnt[7:0]}, {8'd1, 8'd1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per UART bit; legal range is 4..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port uart_rx, input, 1 bit: asynchronous serial line; idle high; 8N1 framing, LSB first.
REQ-005 The block SHALL have port rx_data, output, 8 bits: last accepted byte.
REQ-006 The block SHALL have port rx_valid, output, 1 bit: rx_data holds an unconsumed byte.
REQ-007 The block SHALL have port rx_ready, input, 1 bit: consumer accepts rx_data when high together with rx_valid.
REQ-008 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-009 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed byte is dropped.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 uart_rx SHALL pass through a two-flop synchronizer, whose output is rx_s, before any use; synchronizer flops reset to 1.
REQ-012 The state machine SHALL have states IDLE, START, DATA, STOP and BREAK.
REQ-013 A bit-phase counter of width ceil(log2(CLKS_PER_BIT)) SHALL be used, plus a 3-bit bit index.
REQ-014 IDLE: rx_s==0 SHALL move to START with the counter cleared.
REQ-015 START: at counter==CLKS_PER_BIT/2-1 (integer division), rx_s==0 SHALL move to DATA with the counter cleared, and rx_s==1 SHALL return to IDLE as a glitch, with no flag.
REQ-016 DATA: at counter==CLKS_PER_BIT-1, rx_s SHALL be shifted into shift-register bit [7] with a right shift (LSB first); the counter SHALL clear and the index SHALL increment.
REQ-017 DATA: after the 8th sample (index wraps 7->0), the machine SHALL move to STOP.
REQ-018 STOP: at counter==CLKS_PER_BIT-1, rx_s==1 SHALL complete the byte and move to IDLE.
REQ-019 STOP: at counter==CLKS_PER_BIT-1, rx_s==0 SHALL pulse frame_err for one cycle, discard the byte and move to BREAK.
REQ-020 BREAK: the machine SHALL stay until rx_s==1, then move to IDLE; a line held low SHALL produce exactly one frame_err.
REQ-021 Byte completion with rx_valid==0 SHALL load rx_data and set rx_valid on the next edge.
REQ-022 Handshake: rx_valid&&rx_ready SHALL clear rx_valid on the next edge; rx_data SHALL then hold its value.
REQ-023 rx_valid SHALL NOT drop without a handshake, and rx_data SHALL NOT change while rx_valid==1 except per REQ-025.
REQ-024 Completion with rx_valid==1 and rx_ready==0 SHALL drop the new byte, keep the old rx_data, and pulse overrun for one cycle.
REQ-025 Completion in the same cycle as a handshake SHALL load the new byte and keep rx_valid==1, with no overrun.
REQ-026 Total latency SHALL be: rx_valid rises at most 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the uart_rx falling edge.
REQ-027 rx_ready SHALL be ignored when rx_valid==0.

Reset
REQ-028 rst_n low SHALL, asynchronously, set the state to IDLE and clear the counter, index and shift register.
REQ-029 rst_n low SHALL also set rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0 and synchronizer flops=1.
REQ-030 Reset asserted mid-frame SHALL abandon the frame without a flag.
REQ-031 After rst_n deasserts, a frame in progress on the line SHALL be treated as a new frame from its next falling edge only.

Verification (CLKS_PER_BIT=8)
REQ-032 Scenario byte 8'hA5 sent 8N1, rx_ready=0 -> rx_valid=1, rx_data=8'hA5; then rx_ready=1 for one cycle -> rx_valid=0 next edge.
REQ-033 Scenario low glitch of 3 cycles on an idle line -> state returns to IDLE, rx_valid, frame_err and overrun all stay 0.
REQ-034 Scenario 8'h3C sent with stop bit 0, then line low for 40 cycles, then high -> exactly one frame_err pulse, rx_valid stays 0, next byte 8'h81 is received correctly.
REQ-035 Scenario 8'h11 then 8'h22 back-to-back with rx_ready=0 -> rx_data=8'h11, one overrun pulse at the 8'h22 stop bit.
REQ-036 Scenario rx_ready pulsed on the exact completion cycle of the 2nd byte -> rx_data=8'h22, rx_valid stays 1, no overrun.
REQ-037 Scenario rst_n pulsed low during DATA bit 4 of 8'hFF -> all outputs reset, no flags; the following 8'h5A is received correctly.
